// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter sharing the single-port Data Memory between accelerator
// control units; wide reads, narrow writes, and yields to the CPU while it owns the port.
module acc_mem_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_SIZE    = 16,
    parameter int RD_DATA_SIZE = 512,
    parameter int WR_DATA_SIZE = 32,
    parameter int RD_LATENCY   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_read_en,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]    req_read_addr,
    input  logic [NUM_REQ-1:0]              req_write_en,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]    req_write_addr,
    input  logic [NUM_REQ*WR_DATA_SIZE-1:0] req_write_data,
    output logic [RD_DATA_SIZE-1:0]         req_read_data,
    output logic [NUM_REQ-1:0]              req_read_data_valid,
    output logic [NUM_REQ-1:0]              req_write_done,
    input  logic                            cpu_access,
    output logic [ADDR_SIZE-1:0]            mem_addr,
    output logic                            mem_rd_en,
    output logic                            mem_wr_en,
    output logic [WR_DATA_SIZE-1:0]         mem_wr_data,
    input  logic [RD_DATA_SIZE-1:0]         mem_rd_data
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]              state_r;
    logic [ID_W-1:0]         rr_ptr_r;
    logic [ID_W-1:0]         grant_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [RD_DATA_SIZE-1:0] rdata_r;
    logic [NUM_REQ-1:0]      valid_r;
    logic [NUM_REQ-1:0]      done_r;

    logic [NUM_REQ-1:0]      pending_s;
    logic                    found_s;
    logic [ID_W-1:0]         win_s;
    logic                    issue_s;
    logic                    is_rd_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    assign pending_s = req_read_en | req_write_en;

    // Round-robin search for the first pending requester at or after rr_ptr.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (!found_s && pending_s[idx]) begin
                found_s = 1'b1;
                win_s   = ID_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Reset gates issue so the memory strobes drop asynchronously with rst_n.
    assign issue_s = rst_n && (state_r == ST_IDLE) && !cpu_access && found_s;
    assign is_rd_s = req_read_en[win_s];

    // Combinational memory port drive, zero whenever nothing is issued.
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (issue_s) begin
            if (is_rd_s) begin
                mem_rd_en = 1'b1;
                mem_addr  = req_read_addr[int'(win_s)*ADDR_SIZE +: ADDR_SIZE];
            end else begin
                mem_wr_en   = 1'b1;
                mem_addr    = req_write_addr[int'(win_s)*ADDR_SIZE +: ADDR_SIZE];
                mem_wr_data = req_write_data[int'(win_s)*WR_DATA_SIZE +: WR_DATA_SIZE];
            end
        end else begin
            mem_rd_en = 1'b0;
        end
    end

    // FSM, latency counter, read-data capture and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            grant_r  <= '0;
            cnt_r    <= '0;
            rdata_r  <= '0;
            valid_r  <= '0;
            done_r   <= '0;
        end else begin
            valid_r <= '0;
            done_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        grant_r <= win_s;
                        if (is_rd_s) begin
                            cnt_r   <= CNT_W'(RD_LATENCY - 1);
                            state_r <= ST_RD_WAIT;
                        end else begin
                            done_r  <= onehot(win_s);
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_r == '0) begin
                        rdata_r <= mem_rd_data;
                        valid_r <= onehot(grant_r);
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    rr_ptr_r <= (grant_r == ID_W'(NUM_REQ - 1)) ? '0 : grant_r + ID_W'(1);
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_read_data       = rdata_r;
    assign req_read_data_valid = valid_r;
    assign req_write_done      = done_r;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed bench for acc_mem_arbiter with RD_LATENCY=2 and a two-stage memory model.
module tb_acc_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int RW = 512;
    localparam int WW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_read_en;
    logic [N*AW-1:0] req_read_addr;
    logic [N-1:0]    req_write_en;
    logic [N*AW-1:0] req_write_addr;
    logic [N*WW-1:0] req_write_data;
    logic [RW-1:0]   req_read_data;
    logic [N-1:0]    req_read_data_valid;
    logic [N-1:0]    req_write_done;
    logic            cpu_access;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic [WW-1:0]   mem_wr_data;
    logic [RW-1:0]   mem_rd_data;

    logic [RW-1:0]   rd_pattern;
    logic [RW-1:0]   stage1;
    logic [RW-1:0]   stage2;

    int n_cmp;
    int n_err;

    acc_mem_arbiter #(
        .NUM_REQ(N), .ADDR_SIZE(AW), .RD_DATA_SIZE(RW), .WR_DATA_SIZE(WW), .RD_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read_en(req_read_en), .req_read_addr(req_read_addr),
        .req_write_en(req_write_en), .req_write_addr(req_write_addr),
        .req_write_data(req_write_data),
        .req_read_data(req_read_data), .req_read_data_valid(req_read_data_valid),
        .req_write_done(req_write_done), .cpu_access(cpu_access),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns rd_pattern two cycles after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) stage1 <= rd_pattern;
        stage2 <= stage1;
    end
    assign mem_rd_data = stage2;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (req_read_data !== '0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", req_read_data); end
        n_cmp++; if (req_read_data_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b expected 0000", req_read_data_valid); end
        n_cmp++; if (req_write_done !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b expected 0000", req_write_done); end
        n_cmp++; if ({mem_rd_en, mem_wr_en, mem_addr, mem_wr_data} !== '0) begin n_err++; $display("FAIL reset_mem: got rd=%b wr=%b addr=%h data=%h expected all 0", mem_rd_en, mem_wr_en, mem_addr, mem_wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        @(negedge clk);
        rd_pattern = {64{8'hA5}};
        req_read_addr[1*AW +: AW] = 16'h1000;
        req_read_en = 4'b0010;
        #1;
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h1000) begin n_err++; $display("FAIL read_issue: got rd=%b addr=%h expected rd=1 addr=1000", mem_rd_en, mem_addr); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (mem_rd_en !== 1'b0 || req_read_data_valid !== 4'b0000) begin n_err++; $display("FAIL read_wait%0d: got rd=%b valid=%b expected rd=0 valid=0000", c, mem_rd_en, req_read_data_valid); end
        end
        @(negedge clk); #1;
        n_cmp++; if (req_read_data_valid !== 4'b0010) begin n_err++; $display("FAIL read_valid: got %b expected 0010", req_read_data_valid); end
        n_cmp++; if (req_read_data !== {64{8'hA5}}) begin n_err++; $display("FAIL read_data: got %h expected a5..a5", req_read_data); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL read_done_noissue: got %b expected 0", mem_rd_en); end
        req_read_en = 4'b0000;
        @(negedge clk); #1;
        n_cmp++; if (req_read_data_valid !== 4'b0000) begin n_err++; $display("FAIL read_pulse_len: got %b expected 0000", req_read_data_valid); end
    endtask

    task automatic test_write();
        @(negedge clk);
        req_write_addr[2*AW +: AW] = 16'h5000;
        req_write_data[2*WW +: WW] = 32'h5;
        req_write_en = 4'b0100;
        #1;
        n_cmp++; if (mem_wr_en !== 1'b1 || mem_addr !== 16'h5000 || mem_wr_data !== 32'h5) begin n_err++; $display("FAIL write_issue: got wr=%b addr=%h data=%h expected wr=1 addr=5000 data=5", mem_wr_en, mem_addr, mem_wr_data); end
        @(negedge clk); #1;
        n_cmp++; if (req_write_done !== 4'b0100) begin n_err++; $display("FAIL write_done: got %b expected 0100", req_write_done); end
        n_cmp++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin n_err++; $display("FAIL write_done_noissue: got wr=%b rd=%b expected 0 0", mem_wr_en, mem_rd_en); end
        n_cmp++; if (req_read_data !== {64{8'hA5}}) begin n_err++; $display("FAIL write_keeps_rdata: got %h expected a5..a5", req_read_data); end
        req_write_en = 4'b0000;
        @(negedge clk); #1;
        n_cmp++; if (req_write_done !== 4'b0000) begin n_err++; $display("FAIL write_pulse_len: got %b expected 0000", req_write_done); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] order [4];
        logic [1:0] g;
        order[0] = 2'd0; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
        test_reset();
        for (int i = 0; i < N; i++) begin
            req_write_addr[i*AW +: AW] = 16'h2000 + AW'(i);
            req_write_data[i*WW +: WW] = 32'hB000_0000 + WW'(i);
        end
        req_write_en = 4'b1101;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            g = order[c / 2];
            if (c % 2 == 0) begin
                n_cmp++; if (mem_wr_en !== 1'b1 || mem_addr !== 16'h2000 + AW'(g)) begin n_err++; $display("FAIL rr_issue%0d: got wr=%b addr=%h expected wr=1 addr=%h", c, mem_wr_en, mem_addr, 16'h2000 + AW'(g)); end
                n_cmp++; if (req_write_done !== 4'b0000) begin n_err++; $display("FAIL rr_gap%0d: got %b expected 0000", c, req_write_done); end
            end else begin
                n_cmp++; if (req_write_done !== (4'b0001 << g)) begin n_err++; $display("FAIL rr_done%0d: got %b expected %b", c, req_write_done, 4'b0001 << g); end
            end
        end
        req_write_en = 4'b0000;
    endtask

    task automatic test_cpu_access();
        @(negedge clk);
        rd_pattern = {16{32'hDEADBEEF}};
        req_read_addr[0 +: AW] = 16'h0C00;
        req_read_en = 4'b0001;
        cpu_access = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_cmp++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin n_err++; $display("FAIL cpu_block%0d: got rd=%b wr=%b expected 0 0", c, mem_rd_en, mem_wr_en); end
        end
        @(negedge clk);
        cpu_access = 1'b0;
        #1;
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0C00) begin n_err++; $display("FAIL cpu_release_issue: got rd=%b addr=%h expected rd=1 addr=0c00", mem_rd_en, mem_addr); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (req_read_data_valid !== 4'b0001 || req_read_data !== {16{32'hDEADBEEF}}) begin n_err++; $display("FAIL cpu_read_valid: got valid=%b data=%h expected 0001 deadbeef..", req_read_data_valid, req_read_data); end
        req_read_en = 4'b0000;
    endtask

    task automatic test_read_write_same();
        @(negedge clk);
        rd_pattern = {32{16'h1234}};
        req_read_addr[1*AW +: AW] = 16'h1111;
        req_write_addr[1*AW +: AW] = 16'h2222;
        req_write_data[1*WW +: WW] = 32'hCAFEF00D;
        req_read_en = 4'b0010;
        req_write_en = 4'b0010;
        #1;
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 16'h1111) begin n_err++; $display("FAIL both_read_first: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=1111", mem_rd_en, mem_wr_en, mem_addr); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (req_read_data_valid !== 4'b0010 || req_write_done !== 4'b0000) begin n_err++; $display("FAIL both_read_valid: got valid=%b done=%b expected 0010 0000", req_read_data_valid, req_write_done); end
        req_read_en = 4'b0000;
        @(negedge clk); #1;
        n_cmp++; if (mem_wr_en !== 1'b1 || mem_addr !== 16'h2222 || mem_wr_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL both_write_issue: got wr=%b addr=%h data=%h expected 1 2222 cafef00d", mem_wr_en, mem_addr, mem_wr_data); end
        @(negedge clk); #1;
        n_cmp++; if (req_write_done !== 4'b0010 || req_read_data_valid !== 4'b0000) begin n_err++; $display("FAIL both_write_done: got done=%b valid=%b expected 0010 0000", req_write_done, req_read_data_valid); end
        req_write_en = 4'b0000;
        @(negedge clk); #1;
        n_cmp++; if (req_read_data !== {32{16'h1234}}) begin n_err++; $display("FAIL both_rdata_hold: got %h expected 1234..", req_read_data); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        rd_pattern = {8{64'h0F0F_0F0F_0F0F_0F0F}};
        req_read_addr[3*AW +: AW] = 16'h3333;
        req_read_en = 4'b1000;
        #1;
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h3333) begin n_err++; $display("FAIL mid_issue: got rd=%b addr=%h expected 1 3333", mem_rd_en, mem_addr); end
        @(negedge clk);
        req_write_addr[0 +: AW] = 16'h4444;
        req_write_data[0 +: WW] = 32'h0000_4444;
        req_write_en = 4'b0001;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_rd_en, mem_wr_en, mem_addr, mem_wr_data} !== '0 || req_read_data !== '0) begin n_err++; $display("FAIL mid_async_clear: got rd=%b wr=%b addr=%h rdata=%h expected all 0", mem_rd_en, mem_wr_en, mem_addr, req_read_data); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (req_read_data_valid !== 4'b0000 || req_write_done !== 4'b0000) begin n_err++; $display("FAIL mid_no_pulse%0d: got valid=%b done=%b expected 0000 0000", c, req_read_data_valid, req_write_done); end
        end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (mem_wr_en !== 1'b1 || mem_addr !== 16'h4444) begin n_err++; $display("FAIL mid_rr_reset: got wr=%b addr=%h expected wr=1 addr=4444", mem_wr_en, mem_addr); end
        @(negedge clk); #1;
        n_cmp++; if (req_write_done !== 4'b0001) begin n_err++; $display("FAIL mid_write_done: got %b expected 0001", req_write_done); end
        req_write_en = 4'b0000;
        @(negedge clk); #1;
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h3333) begin n_err++; $display("FAIL mid_reissue: got rd=%b addr=%h expected 1 3333", mem_rd_en, mem_addr); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (req_read_data_valid !== 4'b1000 || req_read_data !== {8{64'h0F0F_0F0F_0F0F_0F0F}}) begin n_err++; $display("FAIL mid_read_valid: got valid=%b data=%h expected 1000 0f0f..", req_read_data_valid, req_read_data); end
        req_read_en = 4'b0000;
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        req_read_en    = '0;
        req_read_addr  = '0;
        req_write_en   = '0;
        req_write_addr = '0;
        req_write_data = '0;
        cpu_access     = 1'b0;
        rd_pattern     = '0;
        stage1         = '0;
        stage2         = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_cpu_access();
        test_read_write_same();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acc_mem_arbiter.md
Name: acc_mem_arbiter

Overview:
- Shares the single-port Data Memory between up to NUM_REQ accelerator control units.
- Accepts per-requester read requests (wide, 512-bit) and write requests (narrow, 32-bit), and returns read_data_valid and write_done pulses.
- Yields the memory to the CPU whenever the CPU is accessing it.
- Sits between the accelerator control units and the Data Memory port; requesters hold their enable until they receive the completion pulse.

Parameters:
- NUM_REQ, 4, number of accelerator requesters (2..8).
- ADDR_SIZE, 16, memory address width.
- RD_DATA_SIZE, 512, read data width.
- WR_DATA_SIZE, 32, write data width.
- RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_read_en  in  NUM_REQ  per-requester read request.
- req_read_addr  in  NUM_REQ*ADDR_SIZE  packed read addresses; requester i at [i*ADDR_SIZE +: ADDR_SIZE].
- req_write_en  in  NUM_REQ  per-requester write request.
- req_write_addr  in  NUM_REQ*ADDR_SIZE  packed write addresses.
- req_write_data  in  NUM_REQ*WR_DATA_SIZE  packed write data.
- req_read_data  out  RD_DATA_SIZE  shared registered read data.
- req_read_data_valid  out  NUM_REQ  one-hot 1-cycle pulse.
- req_write_done  out  NUM_REQ  one-hot 1-cycle pulse.
- cpu_access  in  1  CPU owns memory this cycle; arbiter must not issue.
- mem_addr  out  ADDR_SIZE  memory address.
- mem_rd_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_data  out  WR_DATA_SIZE  memory write data.
- mem_rd_data  in  RD_DATA_SIZE  memory read data.

Behaviour:
- Reset values:
  - state IDLE; rr_ptr 0; grant_id 0; latency counter 0; req_read_data 0.
  - All valid/done pulses 0.
  - mem_* outputs are combinational and 0 whenever not issuing.
- FSM states: IDLE, RD_WAIT, DONE.
- IDLE:
  - If cpu_access=1 or no request is pending: mem enables 0, stay in IDLE.
  - Otherwise select winner w, drive that access combinationally in the same cycle, and latch w into grant_id.
- Winner selection:
  - A requester is pending if req_read_en[i] | req_write_en[i].
  - Round-robin: first pending index searching from rr_ptr upward, modulo NUM_REQ.
- Access type:
  - If the winner has both read and write asserted, the read is served; the write stays pending.
  - Read: mem_rd_en=1, mem_addr = its read address; load counter with RD_LATENCY-1; go to RD_WAIT.
  - Write: mem_wr_en=1, mem_addr and mem_wr_data from its write slot; go to DONE.
- RD_WAIT:
  - Mem enables 0.
  - If counter==0: register mem_rd_data into req_read_data and go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - Pulse req_read_data_valid[grant_id] or req_write_done[grant_id] for exactly one cycle, matching the access type.
  - rr_ptr <= (grant_id+1) mod NUM_REQ.
  - Go to IDLE.
  - No issue in DONE, so the requester gets one cycle to drop or change its enable.
- Latency, with issue in cycle T:
  - Write: done pulse at T+1.
  - Read: data sampled at T+RD_LATENCY; valid pulse at T+RD_LATENCY+1.
- Once issued, an access always completes. A requester dropping its enable after issue does not cancel it. cpu_access is ignored outside IDLE; the CPU stalls externally.
- A request dropped before being granted is never served.
- req_read_data holds its value until the next read capture. Writes do not disturb it.
- Maximum throughput: one write per 2 cycles; one read per RD_LATENCY+2 cycles.
- Reset asserted mid-operation: immediate return to reset values. No pulse is emitted for the aborted access.

Test Plan:
- RD_LATENCY=2, req_read_en[1]=1, addr 16'h1000, memory returns 512'hA5…A5 → mem_rd_en at T with addr 16'h1000; req_read_data=A5…A5 and req_read_data_valid=4'b0010 at T+3 only.
- Write: req_write_en[2]=1, addr 16'h5000, data 32'h5 → mem_wr_en at T, mem_wr_data=32'h5; req_write_done=4'b0100 at T+1; no issue at T+1.
- Requesters 0, 2, 3 write continuously from reset → grant order 0, 2, 3, 0 (rr_ptr wraps 3→0), each done spaced 2 cycles apart.
- cpu_access=1 for 5 cycles while req_read_en[0]=1 → mem_rd_en stays 0 throughout; issue occurs in the first cycle cpu_access=0.
- Requester 1 asserts both read and write → read served first with valid pulse; write served on the next eligible IDLE with done pulse.
- rst_n low during RD_WAIT → all outputs 0 asynchronously, no valid pulse, rr_ptr=0; after release, a pending request is re-served from IDLE.
